// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Bundle of the two master request/response ports, the CPU
//               stall output and the single-port RAM side of ram_arbiter.
//               slave  : view taken by the arbiter
//               master : view taken by the masters / RAM model
// Ports       : m0_* CPU data port, m1_* DMA/debug port, m0_stall_o,
//               ram_* RAM device signals (ram_data_i is combinational read data)
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if;
    logic        m0_req_i;
    logic        m0_we_i;
    logic [31:0] m0_addr_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_data_i;
    logic [31:0] m0_data_o;
    logic        m0_ack_o;

    logic        m1_req_i;
    logic        m1_we_i;
    logic [31:0] m1_addr_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_data_i;
    logic [31:0] m1_data_o;
    logic        m1_ack_o;

    logic        m0_stall_o;

    logic        ram_ce_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;

    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_sel_i, m0_data_i,
        output m0_data_o, m0_ack_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_sel_i, m1_data_i,
        output m1_data_o, m1_ack_o,
        output m0_stall_o,
        output ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
        input  ram_data_i
    );

    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_sel_i, m0_data_i,
        input  m0_data_o, m0_ack_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_sel_i, m1_data_i,
        input  m1_data_o, m1_ack_o,
        input  m0_stall_o,
        input  ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
        output ram_data_i
    );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Two-master arbiter in front of a single-port RAM. Each access
//               takes IDLE -> ACCn -> DONE -> IDLE, i.e. one access per three
//               cycles. The request fields are captured on leaving IDLE and the
//               RAM is driven only from those captured registers.
// Config      : ARB_FIXED_PRIO_EN defined   -> m0 wins simultaneous requests
//               ARB_FIXED_PRIO_EN undefined -> round-robin via last_grant
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - ram_arbiter_if.slave (master ports, m0 stall, RAM side)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter (
    input  wire logic     clk,
    input  wire logic     rst,
    ram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        grant_m1;      // winner if the FSM leaves IDLE this cycle
    logic        start;         // IDLE -> ACCn transition this cycle
    logic        cur_master;    // owner of the access in flight (for DONE)
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [3:0]  cap_sel;
    logic [31:0] cap_data;
    logic [31:0] m0_rdata;
    logic [31:0] m1_rdata;

`ifndef ARB_FIXED_PRIO_EN
    logic        last_grant;    // id of the master granted most recently
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        grant_m1 = 1'b0;
        if (bus.m0_req_i && bus.m1_req_i) begin
`ifdef ARB_FIXED_PRIO_EN
            grant_m1 = 1'b0;
`else
            // The master that was not served last goes first.
            grant_m1 = ~last_grant;
`endif
        end else if (bus.m1_req_i) begin
            grant_m1 = 1'b1;
        end
    end

    assign start = (state == IDLE) && (state_nxt != IDLE);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        bus.ram_ce_o = 1'b0;
        bus.ram_we_o = 1'b0;
        bus.m0_ack_o = 1'b0;
        bus.m1_ack_o = 1'b0;
        case (state)
            IDLE: begin
                if (bus.m0_req_i || bus.m1_req_i) begin
                    state_nxt = grant_m1 ? ACC1 : ACC0;
                end
            end
            ACC0, ACC1: begin
                state_nxt    = DONE;
                bus.ram_ce_o = 1'b1;
                bus.ram_we_o = cap_we;
            end
            DONE: begin
                state_nxt    = IDLE;
                bus.m0_ack_o = ~cur_master;
                bus.m1_ack_o = cur_master;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset kills the RAM strobes at once so an in-flight write never
        // commits, and suppresses the ack of an access being discarded.
        if (rst) begin
            bus.ram_ce_o = 1'b0;
            bus.ram_we_o = 1'b0;
            bus.m0_ack_o = 1'b0;
            bus.m1_ack_o = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Request capture and read-data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_master <= 1'b0;
            cap_we     <= 1'b0;
            cap_addr   <= 32'h0;
            cap_sel    <= 4'h0;
            cap_data   <= 32'h0;
            m0_rdata   <= 32'h0;
            m1_rdata   <= 32'h0;
        end else begin
            if (start) begin
                cur_master <= grant_m1;
                cap_we     <= grant_m1 ? bus.m1_we_i   : bus.m0_we_i;
                cap_addr   <= grant_m1 ? bus.m1_addr_i : bus.m0_addr_i;
                cap_sel    <= grant_m1 ? bus.m1_sel_i  : bus.m0_sel_i;
                cap_data   <= grant_m1 ? bus.m1_data_i : bus.m0_data_i;
            end
            // Read data is sampled at the edge ending ACCn; each master's
            // data output otherwise holds its last read result.
            if (state == ACC0 && !cap_we) begin
                m0_rdata <= bus.ram_data_i;
            end
            if (state == ACC1 && !cap_we) begin
                m1_rdata <= bus.ram_data_i;
            end
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;     // m0 wins the first contention
        end else if (start) begin
            last_grant <= grant_m1;
        end
    end
`endif

    assign bus.ram_addr_o = cap_addr;
    assign bus.ram_sel_o  = cap_sel;
    assign bus.ram_data_o = cap_data;
    assign bus.m0_data_o  = m0_rdata;
    assign bus.m1_data_o  = m1_rdata;
    assign bus.m0_stall_o = bus.m0_req_i & ~bus.m0_ack_o;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Scoreboard bench for ram_arbiter. Stimulus pushes expected
//               acks (owner + read data) computed from a transaction-level
//               model; a negedge monitor pops and compares on every ack and
//               checks that data outputs hold between acks.
// Config      : honours ARB_FIXED_PRIO_EN like the design
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic load;
    always #5 clk = ~clk;

    ram_arbiter_if bus();

    ram_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          master;
        bit          we;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          ack_cyc[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] hold [0:1];
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    bit          last_id;
    bit          f_we   [0:1];
    logic [31:0] f_addr [0:1];
    logic [3:0]  f_sel  [0:1];
    logic [31:0] f_data [0:1];

    function automatic logic [31:0] init_val(input int i);
        if (i == 4)  return 32'hDEADBEEF;
        if (i == 8)  return 32'h0;
        return 32'hA5000000 ^ (i * 32'h01030507);
    endfunction

    // RAM device: combinational read, byte-lane write on the rising edge.
    assign bus.ram_data_i = mem[bus.ram_addr_o[7:2]];
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
        end else if (bus.ram_ce_o && bus.ram_we_o) begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_sel_o[b])
                    mem[bus.ram_addr_o[7:2]][8*b +: 8] <= bus.ram_data_o[8*b +: 8];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        bit          am;
        bit          acked [0:1];
        logic [31:0] dout  [0:1];
        exp_t        e;
        acked[0] = 1'b0;
        acked[1] = 1'b0;
        dout[0]  = bus.m0_data_o;
        dout[1]  = bus.m1_data_o;
        if (rst === 1'b1) begin
            hold[0] = 32'h0;
            hold[1] = 32'h0;
        end else begin
            if (bus.m0_ack_o && bus.m1_ack_o) begin
                checks++; errors++;
                $display("FAIL dual_ack: both acks high at cycle %0d, required at most one", cyc);
            end else if (bus.m0_ack_o || bus.m1_ack_o) begin
                am = bus.m1_ack_o;
                acked[am] = 1'b1;
                ack_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: m%0d acked at cycle %0d, required no ack", am, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.master != am) begin
                        errors++;
                        $display("FAIL ack_owner: got m%0d, required m%0d (cycle %0d)", am, e.master, cyc);
                    end else begin
                        if (!e.we) hold[am] = e.data;
                        checks++;
                        if (dout[am] !== hold[am]) begin
                            errors++;
                            $display("FAIL ack_data m%0d: got %h, required %h", am, dout[am], hold[am]);
                        end
                    end
                end
            end
            for (int m = 0; m < 2; m++) begin
                if (!acked[m]) begin
                    checks++;
                    if (dout[m] !== hold[m]) begin
                        errors++;
                        $display("FAIL data_hold m%0d: got %h, required %h (cycle %0d)", m, dout[m], hold[m], cyc);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic set_fields(input bit m, input bit we, input logic [31:0] addr,
                              input logic [3:0] sel, input logic [31:0] data);
        f_we[m] = we; f_addr[m] = addr; f_sel[m] = sel; f_data[m] = data;
        if (m == 1'b0) begin
            bus.m0_we_i = we; bus.m0_addr_i = addr; bus.m0_sel_i = sel; bus.m0_data_i = data;
        end else begin
            bus.m1_we_i = we; bus.m1_addr_i = addr; bus.m1_sel_i = sel; bus.m1_data_i = data;
        end
    endtask

    // Executes master m's current fields against the model memory and
    // queues the ack it must produce.
    task automatic model_push(input bit m);
        int idx;
        idx = int'(f_addr[m][7:2]);
        if (f_we[m]) begin
            for (int b = 0; b < 4; b++)
                if (f_sel[m][b]) ref_mem[idx][8*b +: 8] = f_data[m][8*b +: 8];
            exp_q.push_back(exp_t'{master: m, we: 1'b1, data: 32'h0});
        end else begin
            exp_q.push_back(exp_t'{master: m, we: 1'b0, data: ref_mem[idx]});
        end
    endtask

    // One round: the selected masters request together, each drops its
    // request on the edge after its own ack.
    task automatic run_round(input bit use0, input bit use1);
        bit w;
        bit pend0, pend1, a0, a1;
        int guard;
        if (use0 && use1) begin
`ifdef ARB_FIXED_PRIO_EN
            w = 1'b0;
`else
            w = ~last_id;
`endif
            model_push(w);
            model_push(~w);
            last_id = ~w;
        end else begin
            w = use1;
            model_push(w);
            last_id = w;
        end
        bus.m0_req_i = use0;
        bus.m1_req_i = use1;
        pend0 = use0;
        pend1 = use1;
        guard = 0;
        while ((pend0 || pend1) && guard < 30) begin
            @(negedge clk);
            a0 = bus.m0_ack_o;
            a1 = bus.m1_ack_o;
            @(posedge clk); #1;
            if (a0) begin bus.m0_req_i = 1'b0; pend0 = 1'b0; end
            if (a1) begin bus.m1_req_i = 1'b0; pend1 = 1'b0; end
            guard++;
        end
        if (pend0 || pend1) begin
            checks++; errors++;
            $display("FAIL round_timeout: pending m0=%0d m1=%0d, required both acked", pend0, pend1);
            bus.m0_req_i = 1'b0;
            bus.m1_req_i = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        last_id = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int          c0;
        logic [31:0] old;
        rst  = 1'b1;
        load = 1'b1;
        bus.m0_req_i = 1'b0; bus.m1_req_i = 1'b0;
        set_fields(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_fields(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        last_id = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        load = 1'b0;
        @(negedge clk);
        chk("rst_ce", {31'h0, bus.ram_ce_o}, 32'h0);
        chk("rst_we", {31'h0, bus.ram_we_o}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_m0_data", bus.m0_data_o, 32'h0);
        chk("reset_m1_data", bus.m1_data_o, 32'h0);
        chk("reset_acks", {30'h0, bus.m1_ack_o, bus.m0_ack_o}, 32'h0);
        chk("reset_ce", {31'h0, bus.ram_ce_o}, 32'h0);

        // Contention: both masters hold requests for 12 cycles.
        @(posedge clk); #1;
        set_fields(1'b0, 1'b0, 32'h10, 4'hF, 32'h0);
        set_fields(1'b1, 1'b0, 32'h14, 4'hF, 32'h0);
`ifdef ARB_FIXED_PRIO_EN
        repeat (4) model_push(1'b0);
`else
        repeat (2) begin model_push(1'b0); model_push(1'b1); end
        last_id = 1'b1;
`endif
        ack_cyc.delete();
        c0 = cyc;
        bus.m0_req_i = 1'b1;
        bus.m1_req_i = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        bus.m0_req_i = 1'b0;
        bus.m1_req_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("contention_ack_count", ack_cyc.size(), 4);
        for (int i = 0; i < 4 && i < ack_cyc.size(); i++)
            chk($sformatf("contention_ack_cycle%0d", i), ack_cyc[i], c0 + 2 + 3 * i);

        // Single read with latency and stall.
        set_fields(1'b0, 1'b0, 32'h10, 4'hF, 32'h0);
        model_push(1'b0);
        last_id = 1'b0;
        bus.m0_req_i = 1'b1;
        @(negedge clk);
        chk("read_stall_idle", {31'h0, bus.m0_stall_o}, 32'h1);
        @(negedge clk);
        chk("read_stall_acc", {31'h0, bus.m0_stall_o}, 32'h1);
        chk("read_ack_early", {31'h0, bus.m0_ack_o}, 32'h0);
        chk("read_ram_addr", bus.ram_addr_o, 32'h10);
        chk("read_ram_ce", {31'h0, bus.ram_ce_o}, 32'h1);
        @(negedge clk);
        chk("read_ack", {31'h0, bus.m0_ack_o}, 32'h1);
        chk("read_data", bus.m0_data_o, 32'hDEADBEEF);
        chk("read_stall_done", {31'h0, bus.m0_stall_o}, 32'h0);
        @(posedge clk); #1;
        bus.m0_req_i = 1'b0;

        // Byte write from m1.
        set_fields(1'b1, 1'b1, 32'h20, 4'b0010, 32'h11223344);
        run_round(1'b0, 1'b1);
        chk("byte_write_mem", mem[8], 32'h00003300);

        // Reset during ACC1 of a write.
        old = mem[12];
        set_fields(1'b1, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D);
        bus.m1_req_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.m1_req_i = 1'b0;
        @(negedge clk);
        chk("rstacc_we", {31'h0, bus.ram_we_o}, 32'h0);
        chk("rstacc_ce", {31'h0, bus.ram_ce_o}, 32'h0);
        chk("rstacc_ack", {31'h0, bus.m1_ack_o}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_id = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rstacc_idle_ce", {31'h0, bus.ram_ce_o}, 32'h0);
        end
        chk("rstacc_mem", mem[12], old);

        // Request dropped during ACC0.
        @(posedge clk); #1;
        set_fields(1'b0, 1'b0, 32'h14, 4'hF, 32'h0);
        model_push(1'b0);
        last_id = 1'b0;
        bus.m0_req_i = 1'b1;
        @(posedge clk); #1;
        bus.m0_req_i = 1'b0;
        @(negedge clk);
        chk("drop_acc_ce", {31'h0, bus.ram_ce_o}, 32'h1);
        @(negedge clk);
        chk("drop_ack", {31'h0, bus.m0_ack_o}, 32'h1);
        repeat (4) begin
            @(negedge clk);
            chk("drop_no_new_access", {31'h0, bus.ram_ce_o}, 32'h0);
        end
        @(posedge clk); #1;

        // Randomised rounds.
        for (int r = 0; r < 40; r++) begin
            int mask;
            mask = $urandom_range(1, 3);
            for (int m = 0; m < 2; m++)
                set_fields(m[0], 1'($urandom_range(0, 1)),
                           {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                           4'($urandom_range(0, 15)), $urandom);
            run_round(mask[0], mask[1]);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: none; all widths are fixed (32-bit address and data, 4-bit byte select).
REQ-002 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-003 For each master port mN (N=0 CPU data port, N=1 DMA/debug), the block SHALL have these ports:
- mN_req_i  in  1  access request; held high until mN_ack_o.
- mN_we_i  in  1  1=write, 0=read.
- mN_addr_i  in  32  byte address.
- mN_sel_i  in  4  byte-lane select.
- mN_data_i  in  32  write data.
- mN_data_o  out  32  read data, valid while mN_ack_o=1.
- mN_ack_o  out  1  one-cycle completion pulse.
REQ-004 The block SHALL have these stall and RAM-side ports:
- m0_stall_o  out  1  high while m0_req_i=1 and m0_ack_o=0; feeds the CPU stall controller.
- ram_ce_o  out  1  RAM chip enable.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  32  RAM address.
- ram_sel_o  out  4  RAM byte select.
- ram_data_o  out  32  RAM write data.
- ram_data_i  in  32  RAM read data, combinational from ram_addr_o/ram_ce_o.

Function
REQ-005 The FSM SHALL have four states: IDLE, ACC0, ACC1, DONE.
REQ-006 In IDLE with no request, the state SHALL stay IDLE and ram_ce_o SHALL be 0.
REQ-007 In IDLE with exactly one request, the FSM SHALL go to ACCn for that requester.
REQ-008 In IDLE with both requests, the winner SHALL be chosen per REQ-017/REQ-018.
REQ-009 On the IDLE->ACCn edge, the block SHALL capture mN_we/addr/sel/data into internal registers; the RAM outputs SHALL be driven only from these registers.
REQ-010 In ACCn, ram_ce_o SHALL be 1 and ram_we/addr/sel/data_o SHALL equal the captured values. A write SHALL commit at the edge ending ACCn. For a read, ram_data_i SHALL be captured into a read-data register at that same edge.
REQ-011 ACCn SHALL last exactly one cycle and then go to DONE; DONE SHALL go to IDLE unconditionally.
REQ-012 In DONE, mN_ack_o of the granted master SHALL be 1 and mN_data_o SHALL be the captured read data. mN_data_o SHALL hold its value outside DONE and SHALL be 32'h0 after reset.
REQ-013 Latency SHALL be as follows: a request sampled in IDLE at edge E gives ACC in cycle E..E+1, ack in cycle E+1..E+2, and the next arbitration at edge E+3. A continuous requester therefore gets one access per 3 cycles.
REQ-014 A master SHALL drop or renew mN_req_i at the edge after its ack. A request still high in IDLE SHALL be treated as a new access.
REQ-015 If a master drops mN_req_i during ACCn or DONE (protocol violation), the access SHALL still complete and the ack SHALL still pulse.
REQ-016 The non-granted master's ack SHALL remain 0. Its request SHALL stay pending, with no loss and no capture.

Configuration
REQ-017 With macro ARB_FIXED_PRIO_EN defined, m0 SHALL always win a simultaneous request.
REQ-018 Without ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin via a 1-bit last_grant register: the master not granted last wins. last_grant SHALL update on each IDLE->ACCn edge. In this mode, single requests SHALL also update last_grant.

Reset
REQ-019 While rst=1, ram_ce_o and ram_we_o SHALL be forced to 0 combinationally, so that a write in progress is aborted.
REQ-020 At the edge with rst=1, the block SHALL enter IDLE and clear acks and mN_data_o to 0. It SHALL clear the captured fields to 0, and set last_grant=1 so that m0 wins first.
REQ-021 A reset in ACCn or DONE SHALL discard the access; no ack SHALL be issued for it.

Verification
REQ-022 Single read: with RAM[0x10]=0xDEADBEEF, m0 reads 0x10. Required: ack in the 2nd cycle after sampling, m0_data_o=0xDEADBEEF, m0_stall_o high for the 2 preceding cycles.
REQ-023 Byte write: m1 writes 0x11223344 with sel=4'b0010 to 0x20 (RAM 0x0). Required: RAM[0x20]=0x00003300; m0_ack_o stays 0.
REQ-024 Contention, round-robin build: both requesters held high for 12 cycles. Required: grants alternate m0,m1,m0,m1 with acks every 3 cycles. With ARB_FIXED_PRIO_EN, only m0 is granted.
REQ-025 Reset mid-write: m1 write to 0x30, rst=1 during ACC1. Required: ram_we_o=0 that cycle, RAM[0x30] unchanged, no ack, state IDLE.
REQ-026 Request drop: m0 drops req during ACC0. Required: ack still pulses in DONE, and the FSM returns to IDLE with no new access.
